// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder                                                         |
// | Byte-addressed little-endian data memory with programmable wait states.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         c_DEPTH     = 1 << ADDR_BITS;
  localparam bit         c_ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_CNT_INIT  = c_ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [3:0]             r_cnt;
  logic [3:0]             w_nextCnt;

  logic                   r_write;
  logic [63:0]            r_addr;
  logic [63:0]            r_wdata;
  logic [3:0]             r_size;

  logic                   w_accept;
  logic                   w_doAccess;
  logic                   w_aWrite;
  logic [63:0]            w_aAddr;
  logic [63:0]            w_aWdata;
  logic [3:0]             w_aSize;
  logic [7:0]             w_be;
  logic                   w_misaligned;
  logic                   w_illegal;
  logic [ADDR_BITS-1:0]   w_base;
  logic [63:0]            w_rdata;

  logic [7:0]             mem [0:c_DEPTH-1];

  assign req_ready = (r_state != S_WAIT);
  assign w_accept  = req_valid && req_ready;

  // With no wait states the access uses the request as presented at the accept edge.
  always_comb begin
    w_aWrite   = r_write;
    w_aAddr    = r_addr;
    w_aWdata   = r_wdata;
    w_aSize    = r_size;
    w_doAccess = (r_state == S_WAIT) && (r_cnt == 4'd0);
    if (c_ZERO_WAIT) begin
      w_aWrite   = req_write;
      w_aAddr    = req_addr;
      w_aWdata   = req_wdata;
      w_aSize    = req_size;
      w_doAccess = w_accept;
    end
  end

  always_comb begin
    w_be         = 8'h00;
    w_misaligned = 1'b0;
    case (w_aSize)
      4'd1: begin
        w_be = 8'h01;
      end
      4'd2: begin
        w_be         = 8'h03;
        w_misaligned = w_aAddr[0];
      end
      4'd4: begin
        w_be         = 8'h0F;
        w_misaligned = |w_aAddr[1:0];
      end
      4'd8: begin
        w_be         = 8'hFF;
        w_misaligned = |w_aAddr[2:0];
      end
      default: begin
        w_be         = 8'h00;
        w_misaligned = 1'b0;
      end
    endcase
  end

  assign w_illegal = (w_be == 8'h00) || w_misaligned || (|w_aAddr[63:ADDR_BITS]);
  assign w_base    = w_aAddr[ADDR_BITS-1:0];

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      if (w_be[k]) begin
        w_rdata[8*k +: 8] = mem[w_base + ADDR_BITS'(k)];
      end
    end
  end

  // Array has no reset; the reset level still blocks writes so pending stores are dropped.
  always_ff @(posedge clk) begin
    if (reset && w_doAccess && !w_illegal && w_aWrite) begin
      for (int k = 0; k < 8; k++) begin
        if (w_be[k]) begin
          mem[w_base + ADDR_BITS'(k)] <= w_aWdata[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (c_ZERO_WAIT) begin
            w_nextState = S_RESP;
          end else begin
            w_nextState = S_WAIT;
            w_nextCnt   = c_CNT_INIT;
          end
        end else begin
          w_nextState = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_nextCnt = r_cnt - 4'd1;
        end else begin
          w_nextState = S_RESP;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= 4'd0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= w_doAccess;
      resp_err   <= w_doAccess && w_illegal;
      resp_rdata <= (w_doAccess && !w_illegal && !w_aWrite) ? w_rdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_data_mem_responder                                                      |
// | Directed bench for data_mem_responder (WAIT_CYCLES = 2 and 0 instances).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_size = 4'd8;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0;
  logic [63:0] z_req_addr = '0, z_req_wdata = '0;
  logic [3:0]  z_req_size = 4'd8;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [63:0] z_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
    .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  // One request on the WAIT_CYCLES=2 instance; lat counts edges from accept to response.
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] wd,
                      input logic [3:0] sz, output logic [63:0] rd, output logic er,
                      output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL xact_timeout addr=%h: no response within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic er; int lat;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b1;
    xact(1'b1, 64'h20, 64'h0, 4'd8, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hDEADBEEF; req_size = 4'd8;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_wait[%0d]: valid=%b ready=%b, required 0 1", i, resp_valid, req_ready);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_after_release[%0d]: valid=%b ready=%b, required 0 1", i, resp_valid, req_ready);
      end
    end
    xact(1'b0, 64'h20, 64'h0, 4'd8, rd, er, lat);
    checks++;
    if (rd !== 64'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_dropped_store: rdata=%h err=%b, required 0 0", rd, er);
    end
  endtask

  task automatic test_full_width();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h10, 64'h0123456789ABCDEF, 4'd8, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 64'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: latency=%0d rdata=%h err=%b, required 2 0 0", lat, rd, er);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_one_cycle: valid=%b, required 0", resp_valid);
    end
    xact(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
    checks++;
    if (rd !== 64'h0123456789ABCDEF || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL load8: rdata=%h err=%b lat=%0d, required 0123456789abcdef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_subwidth();
    logic [63:0] rd; logic er; int lat;
    logic [63:0] addrs [3] = '{64'h10, 64'h12, 64'h14};
    logic [3:0]  sizes [3] = '{4'd1, 4'd2, 4'd4};
    logic [63:0] exps  [3] = '{64'hEF, 64'h89AB, 64'h01234567};
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, addrs[i], 64'h0, sizes[i], rd, er, lat);
      checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL subwidth_load[%0d]: rdata=%h err=%b, required %h 0", i, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h11, 64'hFFFFFFFFFFFFFFAA, 4'd1, rd, er, lat);
    xact(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
    checks++;
    if (rd !== 64'h0123456789ABAAEF || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_store: rdata=%h err=%b, required 0123456789abaaef 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat;
    logic        wrs   [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] addrs [3] = '{64'h12, 64'h10, 64'h400};
    logic [3:0]  sizes [3] = '{4'd4, 4'd3, 4'd8};
    for (int i = 0; i < 3; i++) begin
      xact(wrs[i], addrs[i], 64'hFFFFFFFFFFFFFFFF, sizes[i], rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 64'h0) begin
        errors++;
        $display("FAIL error_case[%0d]: err=%b rdata=%h, required 1 0", i, er, rd);
      end
    end
    xact(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
    checks++;
    if (rd !== 64'h0123456789ABAAEF || er !== 1'b0) begin
      errors++;
      $display("FAIL error_no_effect: rdata=%h err=%b, required 0123456789abaaef 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic        wrs   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] addrs [8] = '{64'h40, 64'h40, 64'h48, 64'h48, 64'h50, 64'h50, 64'h60, 64'h60};
    logic [3:0]  sizes [8] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd4, 4'd4, 4'd2, 4'd2};
    logic [63:0] wds   [8] = '{64'h1122334455667788, 64'h0, 64'h8877665544332211, 64'h0,
                               64'hCAFEF00DDEADBEEF, 64'h0, 64'hAAAABBBBCCCC1234, 64'h0};
    logic [63:0] exps  [8] = '{64'h0, 64'h1122334455667788, 64'h0, 64'h8877665544332211,
                               64'h0, 64'hDEADBEEF, 64'h0, 64'h1234};
    int accCyc [8]; int respCyc [8]; logic [63:0] rds [8]; logic ers [8];
    int idx, nresp, cyc;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      accCyc[i] = 0; respCyc[i] = 0; rds[i] = '0; ers[i] = 1'b0;
    end
    idx = 0; nresp = 0; cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wrs[0]; req_addr = addrs[0]; req_wdata = wds[0]; req_size = sizes[0];
    while (nresp < 8 && cyc < 100) begin
      acc = req_valid && req_ready;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (acc && idx < 8) begin
        accCyc[idx] = cyc;
        idx++;
        if (idx < 8) begin
          req_write = wrs[idx]; req_addr = addrs[idx]; req_wdata = wds[idx]; req_size = sizes[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid) begin
        rds[nresp] = resp_rdata; ers[nresp] = resp_err; respCyc[nresp] = cyc;
        nresp++;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nresp != 8) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d, required 8", nresp);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (accCyc[i] - accCyc[i-1] != 3) begin
        errors++;
        $display("FAIL b2b_accept_spacing[%0d]: %0d cycles, required 3", i, accCyc[i] - accCyc[i-1]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rds[i] !== exps[i] || ers[i] !== 1'b0 || respCyc[i] - accCyc[i] != 2) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: rdata=%h err=%b lat=%0d, required %h 0 2",
                 i, rds[i], ers[i], respCyc[i] - accCyc[i], exps[i]);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic        wrs   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] addrs [8] = '{64'h0, 64'h0, 64'h9, 64'h9, 64'h12, 64'h12, 64'h14, 64'h14};
    logic [3:0]  sizes [8] = '{4'd8, 4'd8, 4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4};
    logic [63:0] wds   [8] = '{64'h0F0E0D0C0B0A0908, 64'h0, 64'h5A, 64'h0,
                               64'hBEEF, 64'h0, 64'h12345678, 64'h0};
    logic [63:0] exps  [8] = '{64'h0, 64'h0F0E0D0C0B0A0908, 64'h0, 64'h5A,
                               64'h0, 64'hBEEF, 64'h0, 64'h12345678};
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = wrs[0]; z_req_addr = addrs[0];
    z_req_wdata = wds[0]; z_req_size = sizes[0];
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (z_resp_valid !== 1'b1 || z_resp_rdata !== exps[k] || z_resp_err !== 1'b0 || z_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_wait[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 %h 0 1",
                 k, z_resp_valid, z_resp_rdata, z_resp_err, z_req_ready, exps[k]);
      end
      if (k < 7) begin
        z_req_write = wrs[k+1]; z_req_addr = addrs[k+1];
        z_req_wdata = wds[k+1]; z_req_size = sizes[k+1];
      end else begin
        z_req_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (z_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait_drain: valid=%b, required 0", z_resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_width();
    test_subwidth();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data-memory port. It accepts one load/store request at a time over a valid/ready channel and performs a byte-addressed, little-endian access of 1, 2, 4 or 8 bytes after a programmable number of wait states. It returns a one-cycle response carrying the read data or an error flag. It replaces the zero-latency data memory behind the pipeline's MEM stage, so the core's stall logic can be exercised against real memory latency.

## Interface
Parameters:
- ADDR_BITS, 10: byte-address width of the backing array (2^ADDR_BITS bytes).
- WAIT_CYCLES, 2: wait states between accept and access. Legal range 0–15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data; the transfer uses the low size×8 bits.
- req_size  in  4  transfer size in bytes: 1, 2, 4 or 8. Any other value is illegal.
- resp_valid  out  1  response present; high for exactly one cycle per request, with no backpressure.
- resp_rdata  out  64  load data, zero-extended. Driven to 0 for stores and for errors.
- resp_err  out  1  request was illegal and had no effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- req_ready = 1 in IDLE and RESP, and 0 in WAIT.
- A request is accepted on a rising edge where req_valid & req_ready. At that edge the block latches write, addr, wdata and size.
- Transitions on accept:
  - If WAIT_CYCLES > 0: go to WAIT with cnt = WAIT_CYCLES−1.
  - If WAIT_CYCLES = 0: perform the access at the accept edge and go to RESP.
- In WAIT:
  - If cnt ≠ 0: decrement cnt.
  - If cnt = 0: perform the access at the next edge and go to RESP.
- Leaving RESP:
  - With a new accept: follow the accept rules above.
  - Otherwise: go to IDLE.
- Access, performed at a single edge:
  - Store: write bytes addr..addr+size−1. Byte addr+k receives wdata[8k+7:8k].
  - Load: resp_rdata[8k+7:8k] = byte addr+k for k < size. Upper bits are 0.
  - resp_valid, resp_rdata and resp_err are registered at this same edge.
- An access is illegal if any of the following holds:
  - req_size ∉ {1,2,4,8};
  - addr mod size ≠ 0;
  - addr ≥ 2^ADDR_BITS (any of req_addr[63:ADDR_BITS] set).
- Illegal access: no array write, resp_err = 1, resp_rdata = 0.
- Accesses complete strictly in acceptance order. A load accepted after a store to the same bytes returns the stored data.
- The memory array is not reset and its contents survive reset.

## Timing
- Reset values (while reset = 0 and after release):
  - state = IDLE, cnt = 0.
  - req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Request inputs are ignored while reset = 0.
- Latency: for a request accepted at edge E, the access happens at edge E+WAIT_CYCLES and resp_valid is high during cycle [E+WAIT_CYCLES, E+WAIT_CYCLES+1).
- Throughput: with req_valid held high, one request is accepted every WAIT_CYCLES+1 cycles. Acceptance occurs in the RESP cycle, so there are no idle bubbles. With WAIT_CYCLES = 0 this is one request per cycle, with resp_valid continuously high.
- Reset asserted mid-WAIT: the pending access is dropped. A pending store never modifies the array and no response is produced.
- Reset asserted during RESP: resp_valid clears immediately (asynchronous). The access has already committed.
- Simultaneous response and accept in RESP: the current response is presented and the new request is latched. The two do not interact.
- cnt is 4 bits wide. The block never decrements below 0 and never wraps.

## Test plan
All scenarios use WAIT_CYCLES = 2 unless noted.
- Reset: drive reset = 0 during WAIT of a store of 0xDEADBEEF to 0x20, then release. Required:
  - resp_valid = 0 throughout; req_ready = 1.
  - A subsequent 8-byte load of 0x20 returns the pre-reset contents (written beforehand as 0).
- Full-width round trip: 8-byte store of 0x0123456789ABCDEF to 0x10 at edge E. Required:
  - resp_valid is high only in cycle E+2..E+3, with resp_err = 0 and resp_rdata = 0.
  - A following 8-byte load of 0x10 returns 0x0123456789ABCDEF.
- Sub-width loads from 0x10 after the store above:
  - size 1 at 0x10 → 0xEF;
  - size 2 at 0x12 → 0x89AB;
  - size 4 at 0x14 → 0x01234567.
- Byte store: size 1 at 0x11 with wdata = 0xFFFFFFFFFFFFFFAA, then an 8-byte load of 0x10 → 0x0123456789ABAAEF.
- Errors: each of the following gives resp_err = 1 and resp_rdata = 0, and 0x10–0x17 remain unchanged on re-read:
  - size-4 store to 0x12;
  - size-3 load of 0x10;
  - 8-byte store to 2^ADDR_BITS.
- Back-to-back traffic with req_valid held high:
  - WAIT_CYCLES = 2: 4 alternating store/load pairs give accepts every 3 cycles, and each load returns the immediately preceding store's data.
  - WAIT_CYCLES = 0: resp_valid stays high for 8 consecutive cycles.
